// File: rtl/serial_to_parallel_rx.sv
// serial_to_parallel_rx: receive end of the serial link.
// Finds byte alignment by searching for COM_SYM. Declares lock after COM_COUNT
// consecutive aligned COMs, then delivers bytes plus a valid flag.
// A COM received while locked is idle, reported as valid_out=0.
// Optional: define RX_STATS_EN to add rx_byte_count, a saturating count of
// the data bytes delivered while locked.
module serial_to_parallel_rx #(
   parameter logic [7:0]  COM_SYM   = 8'hBC,
   parameter int unsigned COM_COUNT = 4       // legal 1..15
) (
   input  logic        clk8f,
   input  logic        reset,
   input  logic        data_in,
   output logic        active,
   output logic [7:0]  data_out,
   output logic        valid_out
`ifdef RX_STATS_EN
   ,output logic [15:0] rx_byte_count
`endif
);

   typedef enum logic [1:0] {ST_UNLOCKED, ST_LOCKING, ST_LOCKED} state_t;

   localparam logic [3:0] COM_TGT = 4'(COM_COUNT);

   state_t     state, state_nx;
   // Only the 7 most recent bits are kept; the byte completes with data_in.
   logic [6:0] sr;
   logic [2:0] bit_cnt, bit_cnt_nx;
   logic [3:0] com_cnt, com_cnt_nx, com_inc;
   logic [7:0] nb;
   logic       is_com, boundary;
   logic       active_nx, valid_nx;
   logic [7:0] data_nx;

   assign nb       = {sr, data_in};
   assign is_com   = (nb == COM_SYM);
   assign boundary = (bit_cnt == 3'd7);
   assign com_inc  = com_cnt + 4'd1;

   // State and datapath registers; reset drops lock and discards any partial byte.
   always_ff @(posedge clk8f) begin
      if (reset) begin
         state     <= ST_UNLOCKED;
         sr        <= '0;
         bit_cnt   <= '0;
         com_cnt   <= '0;
         active    <= 1'b0;
         data_out  <= 8'h00;
         valid_out <= 1'b0;
      end else begin
         state     <= state_nx;
         sr        <= nb[6:0];
         bit_cnt   <= bit_cnt_nx;
         com_cnt   <= com_cnt_nx;
         active    <= active_nx;
         data_out  <= data_nx;
         valid_out <= valid_nx;
      end
   end

   // Next-state: bit-wise COM hunt, then byte-wise confirmation of alignment.
   always_comb begin
      state_nx   = state;
      bit_cnt_nx = bit_cnt + 3'd1;
      com_cnt_nx = com_cnt;
      case (state)
         ST_UNLOCKED: begin
            // Bit phase is re-established by the COM that ends the hunt.
            bit_cnt_nx = 3'd0;
            if (is_com) begin
               com_cnt_nx = 4'd1;
               state_nx   = (COM_TGT == 4'd1) ? ST_LOCKED : ST_LOCKING;
            end
         end
         ST_LOCKING: begin
            if (boundary) begin
               if (is_com) begin
                  com_cnt_nx = com_inc;
                  if (com_inc == COM_TGT) state_nx = ST_LOCKED;
               end else begin
                  com_cnt_nx = 4'd0;
                  state_nx   = ST_UNLOCKED;
               end
            end
         end
         ST_LOCKED: ;   // only reset leaves lock
         default:   state_nx = ST_UNLOCKED;
      endcase
   end

   // Outputs: active tracks the next state; data/valid update only at locked boundaries.
   always_comb begin
      active_nx = (state_nx == ST_LOCKED);
      data_nx   = data_out;
      valid_nx  = 1'b0;
      if (state == ST_LOCKED) begin
         valid_nx = valid_out;
         if (boundary) begin
            if (is_com) begin
               valid_nx = 1'b0;
            end else begin
               data_nx  = nb;
               valid_nx = 1'b1;
            end
         end
      end
   end

`ifdef RX_STATS_EN
   // Count of data bytes delivered while locked, saturating at all-ones.
   always_ff @(posedge clk8f) begin
      if (reset)
         rx_byte_count <= 16'h0000;
      else if (state == ST_LOCKED && boundary && !is_com && rx_byte_count != 16'hFFFF)
         rx_byte_count <= rx_byte_count + 16'h0001;
   end
`endif

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Directed bench for serial_to_parallel_rx (COM_SYM=BC, COM_COUNT=4).
module tb_serial_to_parallel_rx;

   logic       clk8f;
   logic       reset;
   logic       data_in;
   logic       active;
   logic [7:0] data_out;
   logic       valid_out;
`ifdef RX_STATS_EN
   logic [15:0] rx_byte_count;
`endif

   int errors = 0;
   int checks = 0;

   serial_to_parallel_rx #(.COM_SYM(8'hBC), .COM_COUNT(4)) dut (
      .clk8f     (clk8f),
      .reset     (reset),
      .data_in   (data_in),
      .active    (active),
      .data_out  (data_out),
      .valid_out (valid_out)
`ifdef RX_STATS_EN
      ,.rx_byte_count (rx_byte_count)
`endif
   );

   initial clk8f = 1'b0;
   always #5 clk8f = ~clk8f;

   // Drive one bit at the falling edge; return 1 time unit after the sampling edge.
   task automatic send_bit(input logic b);
      @(negedge clk8f);
      data_in = b;
      @(posedge clk8f);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
   endtask

   task automatic do_reset();
      @(negedge clk8f);
      reset   = 1'b1;
      data_in = 1'b0;
      @(posedge clk8f);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk8f);
         reset   = 1'b1;
         data_in = 1'($urandom_range(0, 1));
         @(posedge clk8f);
         #1;
      end
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active got=%0b exp=0", active); end
      checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", data_out); end
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", valid_out); end
`ifdef RX_STATS_EN
      checks++; if (rx_byte_count !== 16'h0000) begin errors++; $display("FAIL reset_count got=%h exp=0000", rx_byte_count); end
`endif
      reset = 1'b0;
   endtask

   task automatic test_lock_offset();
      logic [7:0] com = 8'hBC;
      logic [7:0] d   = 8'h5A;
      do_reset();
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      for (int k = 0; k < 3; k++) send_byte(com);
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL lock_after3 active got=%0b exp=0", active); end
      for (int i = 7; i >= 1; i--) send_bit(com[i]);
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL lock_pre_lsb active got=%0b exp=0", active); end
      send_bit(com[0]);
      checks++; if (active !== 1'b1) begin errors++; $display("FAIL lock_on_lsb active got=%0b exp=1", active); end
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL lock_on_lsb valid got=%0b exp=0", valid_out); end
      for (int i = 7; i >= 1; i--) send_bit(d[i]);
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL lock_5a_pre valid got=%0b exp=0", valid_out); end
      send_bit(d[0]);
      checks++; if (data_out !== 8'h5A || valid_out !== 1'b1) begin errors++; $display("FAIL lock_5a got=%h/%0b exp=5a/1", data_out, valid_out); end
      for (int i = 7; i >= 1; i--) begin
         send_bit(com[i]);
         checks++; if (data_out !== 8'h5A || valid_out !== 1'b1) begin errors++; $display("FAIL lock_5a_hold bit%0d got=%h/%0b exp=5a/1", i, data_out, valid_out); end
      end
      send_bit(com[0]);
      checks++; if (data_out !== 8'h5A || valid_out !== 1'b0) begin errors++; $display("FAIL lock_idle got=%h/%0b exp=5a/0", data_out, valid_out); end
   endtask

   // Continues from the locked state left by test_lock_offset (last slot: idle, data 5A).
   task automatic test_idle_locked();
      logic [7:0] bytes [3] = '{8'h33, 8'hBC, 8'h7E};
      logic       ev    [3] = '{1'b1, 1'b0, 1'b1};
      logic [7:0] ed    [3] = '{8'h33, 8'h33, 8'h7E};
      logic       pv = 1'b0;
      logic [7:0] pd = 8'h5A;
      logic [7:0] b;
      for (int s = 0; s < 3; s++) begin
         b = bytes[s];
         for (int i = 7; i >= 1; i--) begin
            send_bit(b[i]);
            checks++; if (data_out !== pd || valid_out !== pv) begin errors++; $display("FAIL idle_hold slot%0d bit%0d got=%h/%0b exp=%h/%0b", s, i, data_out, valid_out, pd, pv); end
         end
         send_bit(b[0]);
         checks++; if (data_out !== ed[s] || valid_out !== ev[s] || active !== 1'b1) begin errors++; $display("FAIL idle_slot%0d got=%h/%0b/%0b exp=%h/%0b/1", s, data_out, valid_out, active, ed[s], ev[s]); end
         pv = ev[s];
         pd = ed[s];
      end
   endtask

   task automatic test_broken_lock();
      do_reset();
      for (int k = 0; k < 3; k++) send_byte(8'hBC);
      send_byte(8'h55);
      checks++; if (active !== 1'b0 || valid_out !== 1'b0 || data_out !== 8'h00) begin errors++; $display("FAIL broken_after55 got=%0b/%0b/%h exp=0/0/00", active, valid_out, data_out); end
      for (int k = 0; k < 3; k++) send_byte(8'hBC);
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL broken_3com active got=%0b exp=0", active); end
      send_byte(8'hBC);
      checks++; if (active !== 1'b1) begin errors++; $display("FAIL broken_relock active got=%0b exp=1", active); end
      send_byte(8'h11);
      checks++; if (data_out !== 8'h11 || valid_out !== 1'b1) begin errors++; $display("FAIL broken_11 got=%h/%0b exp=11/1", data_out, valid_out); end
   endtask

   // Continues locked from test_broken_lock.
   task automatic test_reset_mid();
      logic [7:0] d = 8'hA5;
      send_byte(d);
      checks++; if (data_out !== 8'hA5 || valid_out !== 1'b1) begin errors++; $display("FAIL mid_a5 got=%h/%0b exp=a5/1", data_out, valid_out); end
      send_bit(d[7]); send_bit(d[6]); send_bit(d[5]);
      @(negedge clk8f);
      data_in = d[4];
      reset   = 1'b1;
      @(posedge clk8f);
      #1;
      reset = 1'b0;
      checks++; if (active !== 1'b0 || valid_out !== 1'b0 || data_out !== 8'h00) begin errors++; $display("FAIL mid_reset got=%0b/%0b/%h exp=0/0/00", active, valid_out, data_out); end
      for (int k = 0; k < 3; k++) send_byte(8'hBC);
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL mid_3com active got=%0b exp=0", active); end
      send_byte(8'hBC);
      checks++; if (active !== 1'b1) begin errors++; $display("FAIL mid_relock active got=%0b exp=1", active); end
      send_byte(8'h3C);
      checks++; if (data_out !== 8'h3C || valid_out !== 1'b1) begin errors++; $display("FAIL mid_3c got=%h/%0b exp=3c/1", data_out, valid_out); end
   endtask

`ifdef RX_STATS_EN
   task automatic test_stats();
      do_reset();
      for (int k = 0; k < 4; k++) send_byte(8'hBC);
      send_byte(8'h01); send_byte(8'hBC); send_byte(8'h02); send_byte(8'h03);
      checks++; if (rx_byte_count !== 16'd3) begin errors++; $display("FAIL stats_count got=%0d exp=3", rx_byte_count); end
      do_reset();
      checks++; if (rx_byte_count !== 16'd0) begin errors++; $display("FAIL stats_reset got=%0d exp=0", rx_byte_count); end
   endtask
`endif

   initial begin
      reset   = 1'b0;
      data_in = 1'b0;
      test_reset();
      test_lock_offset();
      test_idle_locked();
      test_broken_lock();
      test_reset_mid();
`ifdef RX_STATS_EN
      test_stats();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
